// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and the
// valid/ready instruction stream towards decode.
//   master : the fetch unit (drives imem_addr and the decode-side stream)
//   slave  : memory/decode/redirect side (drives rdata, redirect, if_ready)
interface fetch_unit_if;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [63:0] if_pc;

   modport master (
      output imem_addr,
      input  imem_rdata,
      input  redirect_valid,
      input  redirect_pc,
      output if_valid,
      input  if_ready,
      output if_instr,
      output if_pc
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      output redirect_valid,
      output redirect_pc,
      input  if_valid,
      output if_ready,
      input  if_instr,
      input  if_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a same-cycle instruction
// memory, buffers {pc, instr} pairs in a small FIFO and hands them to decode
// over valid/ready. A redirect flushes the buffer and restarts fetch.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   fetch_bus  fetch_unit_if.master (imem port, redirect, decode stream)
module fetch_unit #(
   parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master fetch_bus
);

   localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   fetch_entry_t       fifo_q [FIFO_DEPTH];
   logic [63:0]        fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [CNT_W-1:0]   count_q,    count_d;

   logic               not_empty;
   logic               if_valid_c;
   logic               push;
   logic               pop;
   fetch_entry_t       head;

   // Handshake: a redirect hides the head so stale work is never delivered.
   assign not_empty  = (count_q != '0);
   assign if_valid_c = not_empty && !fetch_bus.redirect_valid;
   assign pop        = if_valid_c && fetch_bus.if_ready;
   assign push       = !fetch_bus.redirect_valid &&
                       ((count_q < CNT_W'(FIFO_DEPTH)) || pop);

   assign head = fifo_q[rd_ptr_q];

   // Decode-side outputs; an empty buffer shows a NOP at PC 0.
   assign fetch_bus.if_valid  = if_valid_c;
   assign fetch_bus.if_instr  = not_empty ? head.instr : NOP_INSTR;
   assign fetch_bus.if_pc     = not_empty ? head.pc    : 64'h0;
   assign fetch_bus.imem_addr = fetch_pc_q;

   // Next-state logic; the redirect edge only reloads the PC, so the first
   // instruction of the new stream is pushed on the following edge.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (fetch_bus.redirect_valid) begin
         fetch_pc_d = {fetch_bus.redirect_pc[63:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + 64'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= {RESET_PC[63:2], 2'b00};
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Buffer storage; contents are qualified by count, so no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= fetch_entry_t'{pc: fetch_pc_q, instr: fetch_bus.imem_rdata};
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed sequences push expected
// {pc, instr} pairs; a negedge monitor pops and compares on every delivery.
module tb_fetch_unit;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC   (64'h0),
      .FIFO_DEPTH (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fetch_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory model: two fixed words, address-derived elsewhere.
   function automatic logic [31:0] imem_word(input logic [63:0] a);
      if (a == 64'h0) return 32'h0010_0093;
      if (a == 64'h4) return 32'h0020_0113;
      return {a[31:2], 2'b11} ^ 32'h5A00_0000;
   endfunction

   assign bus.imem_rdata = imem_word(bus.imem_addr);

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_pc(input logic [63:0] pc);
      exp_q.push_back(exp_t'{pc: pc, instr: imem_word(pc)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_drained(input string name);
      check64(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   // Monitor: every accepted instruction must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && bus.if_valid && bus.if_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_delivery: got pc %h instr %h, none expected",
                     bus.if_pc, bus.if_instr);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check64("deliver_pc", bus.if_pc, e.pc);
            check64("deliver_instr", 64'(bus.if_instr), 64'(e.instr));
         end
      end
   end

   initial begin
      rst                = 1'b1;
      bus.if_ready       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 64'h0;

      // Reset state
      #2;
      check64("rst_valid", 64'(bus.if_valid), 64'd0);
      check64("rst_instr", 64'(bus.if_instr), 64'h13);
      check64("rst_pc", bus.if_pc, 64'h0);
      check64("rst_imem_addr", bus.imem_addr, 64'h0);
      tick();
      tick();

      // 1: reset release with if_ready high, one instruction per cycle
      expect_pc(64'h0); expect_pc(64'h4); expect_pc(64'h8); expect_pc(64'hC);
      bus.if_ready = 1'b1;
      rst = 1'b0;
      tick();
      check64("t1_c1_valid", 64'(bus.if_valid), 64'd1);
      check64("t1_c1_pc", bus.if_pc, 64'h0);
      check64("t1_c1_instr", 64'(bus.if_instr), 64'h0010_0093);
      check64("t1_c1_imem_addr", bus.imem_addr, 64'h4);
      tick();
      check64("t1_c2_pc", bus.if_pc, 64'h4);
      check64("t1_c2_instr", 64'(bus.if_instr), 64'h0020_0113);
      tick(); tick(); tick();
      bus.if_ready = 1'b0;
      check_drained("t1_drained");

      // 2: backpressure after reset, FIFO saturates at two entries
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick(); tick();
      check64("t2_addr_full", bus.imem_addr, 64'h8);
      tick(); tick(); tick();
      check64("t2_addr_hold", bus.imem_addr, 64'h8);
      check64("t2_pc_hold", bus.if_pc, 64'h0);
      check64("t2_valid_hold", 64'(bus.if_valid), 64'd1);
      expect_pc(64'h0); expect_pc(64'h4); expect_pc(64'h8); expect_pc(64'hC);
      bus.if_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check64("t2_stream_valid", 64'(bus.if_valid), 64'd1);
         tick();
      end
      bus.if_ready = 1'b0;
      check_drained("t2_drained");

      // 3: redirect with a full FIFO and if_ready high
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h100;
      bus.if_ready       = 1'b1;
      #1;
      check64("t3_valid_in_redirect", 64'(bus.if_valid), 64'd0);
      tick();
      bus.redirect_valid = 1'b0;
      check64("t3_addr_after", bus.imem_addr, 64'h100);
      check64("t3_valid_after", 64'(bus.if_valid), 64'd0);
      expect_pc(64'h100); expect_pc(64'h104);
      tick();
      check64("t3_first_valid", 64'(bus.if_valid), 64'd1);
      check64("t3_first_pc", bus.if_pc, 64'h100);
      tick(); tick();
      bus.if_ready = 1'b0;
      check_drained("t3_drained");

      // 4: misaligned redirect, then back-to-back redirects
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h203;
      tick();
      bus.redirect_valid = 1'b0;
      check64("t4_addr_aligned", bus.imem_addr, 64'h200);
      check64("t4_valid", 64'(bus.if_valid), 64'd0);
      expect_pc(64'h200);
      bus.if_ready = 1'b1;
      tick();
      check64("t4_pc_aligned", bus.if_pc, 64'h200);
      tick();
      bus.if_ready       = 1'b0;
      check_drained("t4_drained");
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h300;
      tick();
      check64("t4_addr_first_redirect", bus.imem_addr, 64'h300);
      bus.redirect_pc    = 64'h400;
      tick();
      bus.redirect_valid = 1'b0;
      check64("t4_addr_last_redirect", bus.imem_addr, 64'h400);
      check64("t4_b2b_valid", 64'(bus.if_valid), 64'd0);
      expect_pc(64'h400);
      bus.if_ready = 1'b1;
      tick();
      check64("t4_b2b_pc", bus.if_pc, 64'h400);
      tick();
      bus.if_ready = 1'b0;
      check_drained("t4_b2b_drained");

      // 5: PC wraps modulo 2^64
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      bus.redirect_valid = 1'b0;
      expect_pc(64'hFFFF_FFFF_FFFF_FFFC); expect_pc(64'h0); expect_pc(64'h4);
      bus.if_ready = 1'b1;
      tick();
      check64("t5_pc_top", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      check64("t5_pc_wrap", bus.if_pc, 64'h0);
      check64("t5_instr_wrap", 64'(bus.if_instr), 64'h0010_0093);
      tick();
      check64("t5_pc_after_wrap", bus.if_pc, 64'h4);
      tick();
      bus.if_ready = 1'b0;
      check_drained("t5_drained");

      // 6: asynchronous reset between edges with two entries buffered
      tick();
      check64("t6_pre_valid", 64'(bus.if_valid), 64'd1);
      check64("t6_pre_pc", bus.if_pc, 64'h8);
      #2;
      rst = 1'b1;
      #1;
      check64("t6_async_valid", 64'(bus.if_valid), 64'd0);
      check64("t6_async_addr", bus.imem_addr, 64'h0);
      check64("t6_async_instr", 64'(bus.if_instr), 64'h13);
      check64("t6_async_pc", bus.if_pc, 64'h0);
      tick();
      expect_pc(64'h0); expect_pc(64'h4);
      bus.if_ready = 1'b1;
      rst = 1'b0;
      tick();
      check64("t6_restart_valid", 64'(bus.if_valid), 64'd1);
      check64("t6_restart_pc", bus.if_pc, 64'h0);
      tick(); tick();
      bus.if_ready = 1'b0;
      tick();
      check_drained("t6_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
